// File: rtl/hci_mem_rr_arbiter_pkg.sv
// Shared defaults and elaboration helpers for the round-robin memory arbiter.
package hci_mem_rr_arbiter_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_BW = 8;
  localparam int DEFAULT_IW = 8;

  // True when an id field of width iw can carry any requester index 0..n-1.
  function automatic bit iw_fits(int n, int iw);
    return iw >= $clog2(n);
  endfunction

endpackage

// File: rtl/hci_mem_rr_arbiter_if.sv
// Requester-side (core) and memory-side (mem) handshake bundles.

// Requester port: req/gnt handshake, single-cycle response.
interface hci_core_intf
  import hci_mem_rr_arbiter_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW,
  parameter int BW = DEFAULT_BW
) ();
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [DW/BW-1:0] boffs;
  logic             lrdy;
  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_opc;

  modport master (
    output req, add, wen, data, be, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc
  );

  modport slave (
    input  req, add, wen, data, be, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc
  );
endinterface

// Memory port: request tagged with an id, response carries it back.
interface hci_mem_intf
  import hci_mem_rr_arbiter_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW,
  parameter int BW = DEFAULT_BW,
  parameter int IW = DEFAULT_IW
) ();
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [IW-1:0]    id;
  logic [DW-1:0]    r_data;
  logic [IW-1:0]    r_id;

  modport master (
    output req, add, wen, data, be, id,
    input  gnt, r_data, r_id
  );

  modport slave (
    input  req, add, wen, data, be, id,
    output gnt, r_data, r_id
  );
endinterface

// File: rtl/hci_mem_rr_arbiter_picker.sv
// Round-robin picker: first requester at or after ptr_i, wrapping mod N.
// Duplicating the request vector and masking off everything below the pointer
// turns the cyclic search into a plain lowest-set-bit search.
module hci_rr_picker #(
  parameter  int N    = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] thermo;
  logic [2*N-1:0] masked;
  logic [IDXW-1:0] idx;
  logic            found;
  logic [N-1:0]    onehot;

  // Masked priority encode over the doubled request vector.
  always_comb begin
    thermo = ~((ONE << ptr_i) - ONE);
    masked = {req_i, req_i} & thermo;
    found  = 1'b0;
    idx    = '0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        idx   = IDXW'(j % N);
      end
    end
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      onehot[k] = found && (idx == IDXW'(k));
    end
  end

  assign gnt_o   = onehot;
  assign idx_o   = idx;
  assign valid_o = found;

endmodule

// File: rtl/hci_mem_rr_arbiter.sv
// N-to-1 round-robin arbiter onto a single memory port with a fixed
// one-cycle response routed back to the requester that won the grant.
module hci_mem_rr_arbiter
  import hci_mem_rr_arbiter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW,
  parameter int BW = DEFAULT_BW,
  parameter int IW = DEFAULT_IW
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  hci_core_intf.slave in [N],
  hci_mem_intf.master out
);

  localparam int IDXW = $clog2(N);
  localparam int BEW  = DW/BW;

  if (!iw_fits(N, IW)) begin : g_iw_check
    $error("hci_mem_rr_arbiter: IW is too narrow to carry a requester index");
  end

  logic [N-1:0]    req_vec;
  logic [N-1:0]    lrdy_vec;
  logic [N-1:0]    wen_vec;
  logic [AW-1:0]   add_arr  [N];
  logic [DW-1:0]   data_arr [N];
  logic [BEW-1:0]  be_arr   [N];
  logic [N-1:0]    unused_boffs;
  logic            unused_rid;

  logic [N-1:0]    pick_gnt;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;
  logic            xfer;

  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] ridx_q, ridx_d;
  logic            rvalid_q, rvalid_d;

  for (genvar g = 0; g < N; g++) begin : g_port
    assign req_vec[g]      = in[g].req;
    assign lrdy_vec[g]     = in[g].lrdy;
    assign wen_vec[g]      = in[g].wen;
    assign add_arr[g]      = in[g].add;
    assign data_arr[g]     = in[g].data;
    assign be_arr[g]       = in[g].be;
    assign unused_boffs[g] = ^in[g].boffs;

    assign in[g].gnt     = pick_gnt[g] & out.gnt & out.req;
    assign in[g].r_valid = rvalid_q & (ridx_q == IDXW'(g));
    assign in[g].r_data  = out.r_data;
    assign in[g].r_opc   = 1'b0;
  end

  assign unused_rid = ^out.r_id;

  hci_rr_picker #(.N(N)) u_picker (
    .req_i   (req_vec),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign xfer   = out.req & out.gnt;
  assign out.id = IW'(win_idx);

  // Forward the winner's request; an idle bus is driven to zero.
  always_comb begin
    out.req  = |req_vec;
    out.add  = '0;
    out.wen  = 1'b0;
    out.data = '0;
    out.be   = '0;
    if (win_valid) begin
      out.add  = add_arr[win_idx];
      out.wen  = wen_vec[win_idx];
      out.data = data_arr[win_idx];
      out.be   = be_arr[win_idx];
    end
  end

  // Next pointer and response tracking; clear overrides a same-cycle grant.
  always_comb begin
    rr_d     = rr_q;
    rvalid_d = xfer;
    ridx_d   = win_idx;
    if (xfer) begin
      rr_d = (win_idx == IDXW'(N-1)) ? '0 : win_idx + 1'b1;
    end
    if (clear_i) begin
      rr_d     = '0;
      rvalid_d = 1'b0;
      ridx_d   = '0;
    end
  end

  // Pointer and pending-response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      ridx_q   <= ridx_d;
    end
  end

  // There is no response buffer: the owner must be ready when data returns.
  a_lrdy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_q |-> lrdy_vec[ridx_q]);

  // The memory must echo the id of the transaction it is answering.
  a_rid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_q |-> (out.r_id[IDXW-1:0] == ridx_q));

endmodule

// File: tb/tb_hci_mem_rr_arbiter.sv
// Bench for hci_mem_rr_arbiter: table of per-cycle request patterns with
// hand-derived grants, a response scoreboard, and a few directed sequences.
module tb_hci_mem_rr_arbiter;
  import hci_mem_rr_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int IW  = 8;
  localparam int BEW = DW/BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_tb;
  logic [N-1:0]   wen_tb;
  logic [AW-1:0]  add_tb  [N];
  logic [DW-1:0]  data_tb [N];
  logic           mgnt_tb;

  logic [N-1:0]   gnt_obs;
  logic [N-1:0]   rv_obs;
  logic [N-1:0]   opc_obs;
  logic [DW-1:0]  rdata_obs [N];

  hci_core_intf #(.DW(DW), .AW(AW), .BW(BW)) in_if [N] ();
  hci_mem_intf  #(.DW(DW), .AW(AW), .BW(BW), .IW(IW)) mem_if ();

  for (genvar g = 0; g < N; g++) begin : g_req
    assign in_if[g].req   = req_tb[g];
    assign in_if[g].add   = add_tb[g];
    assign in_if[g].wen   = wen_tb[g];
    assign in_if[g].data  = data_tb[g];
    assign in_if[g].be    = {BEW{1'b1}};
    assign in_if[g].boffs = '0;
    assign in_if[g].lrdy  = 1'b1;
    assign gnt_obs[g]     = in_if[g].gnt;
    assign rv_obs[g]      = in_if[g].r_valid;
    assign opc_obs[g]     = in_if[g].r_opc;
    assign rdata_obs[g]   = in_if[g].r_data;
  end

  assign mem_if.gnt = mgnt_tb;

  // Simple single-cycle memory: wen=0 writes, wen=1 reads, id echoed back.
  logic [DW-1:0] mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_if.r_data <= '0;
      mem_if.r_id   <= '0;
    end else if (mem_if.req && mem_if.gnt) begin
      if (!mem_if.wen) mem[mem_if.add[9:2]] <= mem_if.data;
      mem_if.r_data <= mem_if.wen ? mem[mem_if.add[9:2]] : '0;
      mem_if.r_id   <= mem_if.id;
    end
  end

  hci_mem_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .in      (in_if),
    .out     (mem_if)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         mg;
    logic         clr;
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         oreq;
    logic [1:0]   rr;
  } vec_t;

  vec_t         tbl [19];
  logic [N-1:0] rv_q [$];
  int           errors = 0;
  int           checks = 0;

  function automatic vec_t v(logic [N-1:0] req, logic mg, logic clr,
                             logic [N-1:0] gnt, logic [1:0] id, logic oreq,
                             logic [1:0] rr);
    vec_t t;
    t.req = req; t.mg = mg; t.clr = clr;
    t.gnt = gnt; t.id = id; t.oreq = oreq; t.rr = rr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check the response from last cycle.
  task automatic tick();
    logic [N-1:0] exp_rv;
    @(negedge clk);
    exp_rv = (rv_q.size() > 0) ? rv_q.pop_front() : '0;
    chk("r_valid", {60'd0, rv_obs}, {60'd0, exp_rv});
  endtask

  initial begin
    // req       mg clr  gnt      id  oreq rr(before)
    tbl[0]  = v(4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    tbl[1]  = v(4'b1111, 1, 0, 4'b0010, 1, 1, 1);
    tbl[2]  = v(4'b1111, 1, 0, 4'b0100, 2, 1, 2);
    tbl[3]  = v(4'b1111, 1, 0, 4'b1000, 3, 1, 3);
    tbl[4]  = v(4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    tbl[5]  = v(4'b0000, 1, 0, 4'b0000, 0, 0, 1);
    tbl[6]  = v(4'b0100, 1, 0, 4'b0100, 2, 1, 1);
    tbl[7]  = v(4'b0100, 1, 0, 4'b0100, 2, 1, 3);
    tbl[8]  = v(4'b0000, 1, 0, 4'b0000, 0, 0, 3);
    tbl[9]  = v(4'b1000, 1, 0, 4'b1000, 3, 1, 3);
    tbl[10] = v(4'b1010, 0, 0, 4'b0000, 1, 1, 0);
    tbl[11] = v(4'b1010, 0, 0, 4'b0000, 1, 1, 0);
    tbl[12] = v(4'b1010, 0, 0, 4'b0000, 1, 1, 0);
    tbl[13] = v(4'b1010, 1, 0, 4'b0010, 1, 1, 0);
    tbl[14] = v(4'b1010, 1, 0, 4'b1000, 3, 1, 2);
    tbl[15] = v(4'b0000, 1, 0, 4'b0000, 0, 0, 0);
    tbl[16] = v(4'b0010, 1, 1, 4'b0010, 1, 1, 0);
    tbl[17] = v(4'b1001, 1, 0, 4'b0001, 0, 1, 0);
    tbl[18] = v(4'b0000, 1, 0, 4'b0000, 0, 0, 1);

    req_tb  = '0;
    wen_tb  = '1;
    mgnt_tb = 1'b1;
    for (int i = 0; i < N; i++) begin
      add_tb[i]  = 32'h100 + 32'(i*4);
      data_tb[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_gnt",    {60'd0, gnt_obs}, 64'd0);
    chk("rst_rvalid", {60'd0, rv_obs},  64'd0);
    chk("rst_oreq",   {63'd0, mem_if.req}, 64'd0);
    chk("rst_rr",     {62'd0, dut.rr_q}, 64'd0);
    rst_n = 1'b1;

    // Table-driven cycles.
    for (int r = 0; r < 19; r++) begin
      tick();
      req_tb  = tbl[r].req;
      mgnt_tb = tbl[r].mg;
      clear   = tbl[r].clr;
      #1;
      chk($sformatf("rr[%0d]", r),   {62'd0, dut.rr_q},   {62'd0, tbl[r].rr});
      chk($sformatf("gnt[%0d]", r),  {60'd0, gnt_obs},    {60'd0, tbl[r].gnt});
      chk($sformatf("oreq[%0d]", r), {63'd0, mem_if.req}, {63'd0, tbl[r].oreq});
      chk($sformatf("id[%0d]", r),   {56'd0, mem_if.id},  {62'd0, tbl[r].id});
      chk($sformatf("add[%0d]", r),  {32'd0, mem_if.add},
          tbl[r].oreq ? 64'h100 + 64'(tbl[r].id) * 4 : 64'd0);
      rv_q.push_back(tbl[r].clr ? '0 : tbl[r].gnt);
    end
    clear = 1'b0;

    // Write then read back through requester 0.
    tick();
    req_tb     = 4'b0001;
    wen_tb[0]  = 1'b0;
    add_tb[0]  = 32'h10;
    data_tb[0] = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt",  {60'd0, gnt_obs},     64'h1);
    chk("wr_wen",  {63'd0, mem_if.wen},  64'h0);
    chk("wr_add",  {32'd0, mem_if.add},  64'h10);
    chk("wr_data", {32'd0, mem_if.data}, 64'hDEAD_BEEF);
    chk("wr_id",   {56'd0, mem_if.id},   64'h0);
    rv_q.push_back(4'b0001);
    tick();
    wen_tb[0]  = 1'b1;
    data_tb[0] = 32'h0;
    #1;
    chk("rd_gnt", {60'd0, gnt_obs},    64'h1);
    chk("rd_wen", {63'd0, mem_if.wen}, 64'h1);
    chk("rd_id",  {56'd0, mem_if.id},  64'h0);
    rv_q.push_back(4'b0001);
    tick();
    chk("rd_data0", {32'd0, rdata_obs[0]}, 64'hDEAD_BEEF);
    chk("rd_data3", {32'd0, rdata_obs[3]}, 64'hDEAD_BEEF);
    chk("r_opc",    {60'd0, opc_obs},      64'h0);

    // Reset while a response is pending: it is dropped immediately.
    req_tb = 4'b0010;
    @(posedge clk);
    #1;
    chk("pend_rv", {60'd0, rv_obs},   64'b0010);
    chk("pend_rr", {62'd0, dut.rr_q}, 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_rv", {60'd0, rv_obs},   64'd0);
    chk("arst_rr", {62'd0, dut.rr_q}, 64'd0);
    req_tb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_oreq", {63'd0, mem_if.req}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
